lsq_mem_arbiter: RTL and testbench

Sequences the single data-memory port between the load buffer (speculative load reads) and ROB store commit (retired store writes). Captures the load buffer's one-cycle read_mem pulse and holds store requests until granted. Drives one memory command at a time, then waits for the memory acknowledge. Returns load data tagged with the ROB tag, and reports mem_busy back to the load buffer.

---
 rtl/lsq_mem_arbiter_if.sv | 50 +++++
 rtl/lsq_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_lsq_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_mem_arbiter_if.sv
// Bundle between the LSQ side (load buffer + store commit) and the data-memory port.
// The arbiter takes the slave modport; whoever drives requests and models memory takes master.
interface lsq_mem_arbiter_if #(
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
);
  // load buffer request
  logic                   ld_req;
  logic [XLEN-1:0]        ld_addr;
  logic [1:0]             ld_size;
  logic [ROB_TAG_LEN-1:0] ld_tag;
  // store commit request
  logic                   st_req;
  logic [XLEN-1:0]        st_addr;
  logic [XLEN-1:0]        st_data;
  logic [1:0]             st_size;
  logic [ROB_TAG_LEN-1:0] st_tag;
  logic                   flush;
  // memory response
  logic                   mem_ack;
  logic [XLEN-1:0]        mem_rdata;
  // arbiter outputs
  logic                   mem_busy;
  logic                   st_grant;
  logic [1:0]             mem_cmd;
  logic [XLEN-1:0]        mem_addr;
  logic [XLEN-1:0]        mem_wdata;
  logic [1:0]             mem_size;
  logic                   ld_done;
  logic [XLEN-1:0]        ld_data;
  logic [ROB_TAG_LEN-1:0] ld_done_tag;
  logic                   st_done;
  logic [ROB_TAG_LEN-1:0] st_done_tag;

  modport slave (
    input  ld_req, ld_addr, ld_size, ld_tag,
    input  st_req, st_addr, st_data, st_size, st_tag,
    input  flush, mem_ack, mem_rdata,
    output mem_busy, st_grant, mem_cmd, mem_addr, mem_wdata, mem_size,
    output ld_done, ld_data, ld_done_tag, st_done, st_done_tag
  );

  modport master (
    output ld_req, ld_addr, ld_size, ld_tag,
    output st_req, st_addr, st_data, st_size, st_tag,
    output flush, mem_ack, mem_rdata,
    input  mem_busy, st_grant, mem_cmd, mem_addr, mem_wdata, mem_size,
    input  ld_done, ld_data, ld_done_tag, st_done, st_done_tag
  );
endinterface

// File: rtl/lsq_mem_arbiter.sv
// Single data-memory port arbiter between speculative loads and committed stores.
// One command in flight; loads can be squashed by flush, stores always complete.
module lsq_mem_arbiter #(
  parameter int XLEN             = 32,
  parameter int ROB_TAG_LEN      = 5,
  parameter int STORE_STREAK_MAX = 4
) (
  input logic clock,
  input logic reset,
  lsq_mem_arbiter_if.slave bus
);
  localparam int STREAK_W = $clog2(STORE_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STORE_STREAK_MAX);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t                 state_reg;
  logic                   ld_pend_reg;
  logic [XLEN-1:0]        pend_addr_reg;
  logic [1:0]             pend_size_reg;
  logic [ROB_TAG_LEN-1:0] pend_tag_reg;
  logic                   op_load_reg;
  logic [ROB_TAG_LEN-1:0] op_tag_reg;
  logic [STREAK_W-1:0]    streak_reg;

  logic [1:0]             mem_cmd_reg;
  logic [XLEN-1:0]        mem_addr_reg;
  logic [XLEN-1:0]        mem_wdata_reg;
  logic [1:0]             mem_size_reg;
  logic                   ld_done_reg;
  logic [XLEN-1:0]        ld_data_reg;
  logic [ROB_TAG_LEN-1:0] ld_done_tag_reg;
  logic                   st_done_reg;
  logic [ROB_TAG_LEN-1:0] st_done_tag_reg;

  logic ld_live;
  logic store_win;
  logic load_win;
  logic kill_load;

  // A flush this cycle already removes the pending load from arbitration.
  assign ld_live   = ld_pend_reg & ~bus.flush;
  assign store_win = (state_reg == IDLE) & bus.st_req &
                     (~ld_live | (streak_reg < STREAK_MAX));
  assign load_win  = (state_reg == IDLE) & ld_live & ~store_win;
  assign kill_load = op_load_reg & bus.flush;

  assign bus.st_grant    = reset & store_win;
  assign bus.mem_busy    = reset & ((state_reg != IDLE) | ld_pend_reg | bus.st_req);
  assign bus.mem_cmd     = mem_cmd_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.mem_size    = mem_size_reg;
  assign bus.ld_done     = ld_done_reg;
  assign bus.ld_data     = ld_data_reg;
  assign bus.ld_done_tag = ld_done_tag_reg;
  assign bus.st_done     = st_done_reg;
  assign bus.st_done_tag = st_done_tag_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      ld_pend_reg     <= 1'b0;
      pend_addr_reg   <= '0;
      pend_size_reg   <= '0;
      pend_tag_reg    <= '0;
      op_load_reg     <= 1'b0;
      op_tag_reg      <= '0;
      streak_reg      <= '0;
      mem_cmd_reg     <= CMD_NONE;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_size_reg    <= '0;
      ld_done_reg     <= 1'b0;
      ld_data_reg     <= '0;
      ld_done_tag_reg <= '0;
      st_done_reg     <= 1'b0;
      st_done_tag_reg <= '0;
    end else begin
      ld_done_reg   <= 1'b0;
      st_done_reg   <= 1'b0;
      mem_cmd_reg   <= CMD_NONE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_size_reg  <= '0;

      // A new pulse while a load is held overwrites it; a granted load frees the slot.
      if (bus.flush) begin
        ld_pend_reg <= 1'b0;
      end else if (bus.ld_req) begin
        ld_pend_reg   <= 1'b1;
        pend_addr_reg <= bus.ld_addr;
        pend_size_reg <= bus.ld_size;
        pend_tag_reg  <= bus.ld_tag;
      end else if (load_win) begin
        ld_pend_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (store_win) begin
            op_load_reg   <= 1'b0;
            op_tag_reg    <= bus.st_tag;
            mem_cmd_reg   <= CMD_STORE;
            mem_addr_reg  <= bus.st_addr;
            mem_wdata_reg <= bus.st_data;
            mem_size_reg  <= bus.st_size;
            if (ld_live)
              streak_reg <= (streak_reg == STREAK_MAX) ? streak_reg : streak_reg + 1'b1;
            else
              streak_reg <= '0;
            state_reg <= ISSUE;
          end else if (load_win) begin
            op_load_reg  <= 1'b1;
            op_tag_reg   <= pend_tag_reg;
            mem_cmd_reg  <= CMD_LOAD;
            mem_addr_reg <= pend_addr_reg;
            mem_size_reg <= pend_size_reg;
            streak_reg   <= '0;
            state_reg    <= ISSUE;
          end else begin
            streak_reg <= '0;
          end
        end
        ISSUE: begin
          state_reg <= kill_load ? DRAIN : WAIT;
        end
        WAIT: begin
          if (kill_load) begin
            // The ack arriving with the flush is consumed without a result.
            state_reg <= bus.mem_ack ? IDLE : DRAIN;
          end else if (bus.mem_ack) begin
            state_reg <= IDLE;
            if (op_load_reg) begin
              ld_done_reg     <= 1'b1;
              ld_data_reg     <= bus.mem_rdata;
              ld_done_tag_reg <= op_tag_reg;
            end else begin
              st_done_reg     <= 1'b1;
              st_done_tag_reg <= op_tag_reg;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_ack)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter: loads, stores, store streak limit, flush and async reset.
module tb_lsq_mem_arbiter;
  localparam int XLEN = 32;
  localparam int TAG  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lsq_mem_arbiter_if #(.XLEN(XLEN), .ROB_TAG_LEN(TAG)) bus ();

  lsq_mem_arbiter #(.XLEN(XLEN), .ROB_TAG_LEN(TAG), .STORE_STREAK_MAX(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic init_inputs();
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_size = '0; bus.ld_tag = '0;
    bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = '0; bus.st_tag = '0;
    bus.flush = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    tick(); tick();
    checks++; if (bus.mem_cmd !== 2'd0) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", bus.mem_cmd); end
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.mem_busy); end
    checks++; if (bus.ld_done !== 1'b0 || bus.st_done !== 1'b0 || bus.st_grant !== 1'b0) begin
      errors++; $display("FAIL reset_done: got ld=%0b st=%0b gnt=%0b expected 0", bus.ld_done, bus.st_done, bus.st_grant); end
    reset = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_single_load();
    bus.ld_req = 1; bus.ld_addr = 32'd5; bus.ld_size = 2'd1; bus.ld_tag = 5'd1;
    tick();
    bus.ld_req = 0;
    checks++; if (bus.mem_busy !== 1'b1) begin errors++; $display("FAIL load_busy_pend: got %0b expected 1", bus.mem_busy); end
    checks++; if (bus.mem_cmd !== 2'd0) begin errors++; $display("FAIL load_cmd_idle: got %0d expected 0", bus.mem_cmd); end
    tick();
    checks++; if (bus.mem_cmd !== 2'd1 || bus.mem_addr !== 32'd5 || bus.mem_size !== 2'd1 || bus.mem_wdata !== 32'd0) begin
      errors++; $display("FAIL load_issue: got cmd=%0d addr=%0h size=%0d wdata=%0h expected 1/5/1/0",
                         bus.mem_cmd, bus.mem_addr, bus.mem_size, bus.mem_wdata); end
    tick();
    checks++; if (bus.mem_cmd !== 2'd0 || bus.mem_busy !== 1'b1) begin
      errors++; $display("FAIL load_wait: got cmd=%0d busy=%0b expected 0/1", bus.mem_cmd, bus.mem_busy); end
    bus.mem_ack = 1; bus.mem_rdata = 32'hAB;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b1 || bus.ld_data !== 32'hAB || bus.ld_done_tag !== 5'd1) begin
      errors++; $display("FAIL load_done: got done=%0b data=%0h tag=%0d expected 1/ab/1", bus.ld_done, bus.ld_data, bus.ld_done_tag); end
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL load_busy_idle: got %0b expected 0", bus.mem_busy); end
    tick();
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL load_done_pulse: got %0b expected 0", bus.ld_done); end
    $display("load tag=1 addr=5 data=%0h", bus.ld_data);
  endtask

  task automatic test_store_first();
    bus.ld_req = 1; bus.ld_addr = 32'h40; bus.ld_size = 2'd2; bus.ld_tag = 5'd2;
    tick();
    bus.ld_req = 0;
    bus.st_req = 1; bus.st_addr = 32'd4; bus.st_data = 32'h1234; bus.st_size = 2'd2; bus.st_tag = 5'd3;
    #1;
    checks++; if (bus.st_grant !== 1'b1) begin errors++; $display("FAIL st_grant: got %0b expected 1", bus.st_grant); end
    tick();
    bus.st_req = 0;
    checks++; if (bus.mem_cmd !== 2'd2 || bus.mem_addr !== 32'd4 || bus.mem_wdata !== 32'h1234 || bus.mem_size !== 2'd2) begin
      errors++; $display("FAIL st_issue: got cmd=%0d addr=%0h wdata=%0h size=%0d expected 2/4/1234/2",
                         bus.mem_cmd, bus.mem_addr, bus.mem_wdata, bus.mem_size); end
    checks++; if (bus.st_grant !== 1'b0) begin errors++; $display("FAIL st_grant_pulse: got %0b expected 0", bus.st_grant); end
    tick();
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.st_done !== 1'b1 || bus.st_done_tag !== 5'd3 || bus.ld_done !== 1'b0) begin
      errors++; $display("FAIL st_done: got st=%0b tag=%0d ld=%0b expected 1/3/0", bus.st_done, bus.st_done_tag, bus.ld_done); end
    $display("store tag=3 addr=4 data=1234");
    tick();
    checks++; if (bus.mem_cmd !== 2'd1 || bus.mem_addr !== 32'h40) begin
      errors++; $display("FAIL st_then_load: got cmd=%0d addr=%0h expected 1/40", bus.mem_cmd, bus.mem_addr); end
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'h55;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b1 || bus.ld_done_tag !== 5'd2 || bus.ld_data !== 32'h55) begin
      errors++; $display("FAIL st_then_load_done: got done=%0b tag=%0d data=%0h expected 1/2/55", bus.ld_done, bus.ld_done_tag, bus.ld_data); end
    $display("load tag=2 addr=40 data=%0h", bus.ld_data);
  endtask

  task automatic test_store_streak();
    for (int r = 0; r < 2; r++) begin
      int  grants;
      bit  load_seen;
      bit  issue_prev;
      grants = 0; load_seen = 0; issue_prev = 0;
      bus.ld_req = 1; bus.ld_addr = 32'h80 + r; bus.ld_size = 2'd2; bus.ld_tag = 5'(7 + r);
      tick();
      bus.ld_req = 0;
      bus.st_req = 1; bus.st_addr = 32'h100; bus.st_data = 32'hCAFE; bus.st_size = 2'd2; bus.st_tag = 5'd9;
      for (int c = 0; c < 60; c++) begin
        bus.mem_ack = issue_prev;
        issue_prev = (bus.mem_cmd != 2'd0);
        if (bus.mem_cmd == 2'd1) begin
          load_seen = 1;
          break;
        end
        #1;
        if (bus.st_grant) grants++;
        tick();
      end
      bus.st_req = 0; bus.mem_ack = 0;
      checks++; if (load_seen !== 1'b1) begin errors++; $display("FAIL streak_timeout: got load_seen=%0b expected 1", load_seen); end
      checks++; if (grants != 4) begin errors++; $display("FAIL streak_grants: got %0d expected 4", grants); end
      checks++; if (bus.mem_addr !== 32'h80 + r) begin errors++; $display("FAIL streak_load_addr: got %0h expected %0h", bus.mem_addr, 32'h80 + r); end
      tick();
      bus.mem_ack = 1; bus.mem_rdata = 32'h900 + r;
      tick();
      bus.mem_ack = 0;
      checks++; if (bus.ld_done !== 1'b1 || bus.ld_done_tag !== 5'(7 + r)) begin
        errors++; $display("FAIL streak_load_done: got done=%0b tag=%0d expected 1/%0d", bus.ld_done, bus.ld_done_tag, 7 + r); end
      $display("streak round %0d: %0d store grants then load tag=%0d", r, grants, bus.ld_done_tag);
    end
  endtask

  task automatic test_ack_ignored();
    bus.ld_req = 1; bus.ld_addr = 32'h20; bus.ld_size = 2'd0; bus.ld_tag = 5'd12;
    tick();
    bus.ld_req = 0;
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD;
    tick();
    bus.mem_ack = 0;
    tick();
    checks++; if (bus.ld_done !== 1'b0 || bus.mem_busy !== 1'b1) begin
      errors++; $display("FAIL ack_in_issue: got done=%0b busy=%0b expected 0/1", bus.ld_done, bus.mem_busy); end
    bus.mem_ack = 1; bus.mem_rdata = 32'h66;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b1 || bus.ld_data !== 32'h66 || bus.ld_done_tag !== 5'd12) begin
      errors++; $display("FAIL ack_after_issue: got done=%0b data=%0h tag=%0d expected 1/66/12", bus.ld_done, bus.ld_data, bus.ld_done_tag); end
    $display("load tag=12 data=%0h (early ack ignored)", bus.ld_data);
  endtask

  task automatic test_flush_wait();
    bus.ld_req = 1; bus.ld_addr = 32'h10; bus.ld_size = 2'd2; bus.ld_tag = 5'd2;
    tick();
    bus.ld_req = 0;
    tick();
    tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    checks++; if (bus.mem_busy !== 1'b1 || bus.ld_done !== 1'b0) begin
      errors++; $display("FAIL flush_drain: got busy=%0b done=%0b expected 1/0", bus.mem_busy, bus.ld_done); end
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b0 || bus.mem_busy !== 1'b0) begin
      errors++; $display("FAIL flush_drain_end: got done=%0b busy=%0b expected 0/0", bus.ld_done, bus.mem_busy); end
    $display("load tag=2 flushed in WAIT, drained");
    // flush coinciding with the ack
    bus.ld_req = 1; bus.ld_tag = 5'd6;
    tick();
    bus.ld_req = 0;
    tick();
    tick();
    bus.flush = 1; bus.mem_ack = 1;
    tick();
    bus.flush = 0; bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b0 || bus.mem_busy !== 1'b0) begin
      errors++; $display("FAIL flush_with_ack: got done=%0b busy=%0b expected 0/0", bus.ld_done, bus.mem_busy); end
    $display("load tag=6 flushed with ack");
  endtask

  task automatic test_flush_pending();
    bus.ld_req = 1; bus.flush = 1; bus.ld_addr = 32'h30; bus.ld_tag = 5'd4;
    tick();
    bus.ld_req = 0; bus.flush = 0;
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got busy=%0b expected 0", bus.mem_busy); end
    bus.ld_req = 1;
    tick();
    bus.ld_req = 0;
    checks++; if (bus.mem_busy !== 1'b1) begin errors++; $display("FAIL flush_pend_set: got busy=%0b expected 1", bus.mem_busy); end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_cmd !== 2'd0 || bus.mem_busy !== 1'b0) begin
        errors++; $display("FAIL flush_pend_cmd: got cmd=%0d busy=%0b expected 0/0", bus.mem_cmd, bus.mem_busy); end
      tick();
    end
    $display("pending loads tag=4 dropped by flush");
  endtask

  task automatic test_async_reset();
    bus.ld_req = 1; bus.ld_addr = 32'h50; bus.ld_size = 2'd2; bus.ld_tag = 5'd9;
    tick();
    bus.ld_req = 0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.mem_busy !== 1'b0 || bus.mem_cmd !== 2'd0) begin
      errors++; $display("FAIL async_reset: got busy=%0b cmd=%0d expected 0/0", bus.mem_busy, bus.mem_cmd); end
    tick();
    reset = 1'b1; bus.mem_ack = 1; bus.mem_rdata = 32'hEE;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b0 || bus.st_done !== 1'b0 || bus.mem_busy !== 1'b0) begin
      errors++; $display("FAIL reset_stale_ack: got ld=%0b st=%0b busy=%0b expected 0/0/0", bus.ld_done, bus.st_done, bus.mem_busy); end
    bus.ld_req = 1; bus.ld_addr = 32'h60; bus.ld_tag = 5'd4;
    tick();
    bus.ld_req = 0;
    tick();
    checks++; if (bus.mem_cmd !== 2'd1 || bus.mem_addr !== 32'h60) begin
      errors++; $display("FAIL resume_issue: got cmd=%0d addr=%0h expected 1/60", bus.mem_cmd, bus.mem_addr); end
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    tick();
    bus.mem_ack = 0;
    checks++; if (bus.ld_done !== 1'b1 || bus.ld_data !== 32'h77 || bus.ld_done_tag !== 5'd4) begin
      errors++; $display("FAIL resume_done: got done=%0b data=%0h tag=%0d expected 1/77/4", bus.ld_done, bus.ld_data, bus.ld_done_tag); end
    $display("load tag=4 after reset data=%0h", bus.ld_data);
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_load();
    test_store_first();
    test_store_streak();
    test_ack_ignored();
    test_flush_wait();
    test_flush_pending();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
